// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: command front-end for the Mem TCAM routing memory.
// Queues spike packet IDs, arbitrates them against configuration commands
// and drives Mem's pins. Every operation cycle is followed by one MODE_I cycle.
module mem_cmd_sequencer #(
   parameter int ID_Width    = 4,
   parameter int AddressSize = 4,
   parameter int Bits        = 8,
   parameter int FIFO_Depth  = 8,
   parameter int Cfg_Burst   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          spike_valid,
   output logic                          spike_ready,
   input  logic [ID_Width-1:0]           spike_id,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [1:0]                    cfg_op,
   input  logic [Bits-1:0]               cfg_data,
   input  logic [Bits-1:0]               cfg_mskb,
   input  logic [AddressSize-1:0]        cfg_addr,
   input  logic                          cfg_dcs,
   input  logic                          cfg_vbe,
   input  logic                          cfg_vbi,
   output logic [2:0]                    MODE,
   output logic [ID_Width-1:0]           PacketID_In,
   output logic [Bits-1:0]               Data_In,
   output logic [Bits-1:0]               Mskb_In,
   output logic [AddressSize-1:0]        A_In,
   output logic                          Dcs_In,
   output logic                          Vbe_In,
   output logic                          Vbi_In,
   output logic [$clog2(FIFO_Depth):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_Depth);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(Cfg_Burst + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_Depth);
   localparam logic [SW-1:0] BURST_C = SW'(Cfg_Burst);

   localparam logic [2:0] MODE_I   = 3'b000;
   localparam logic [2:0] MODE_W   = 3'b001;
   localparam logic [2:0] MODE_R   = 3'b010;
   localparam logic [2:0] MODE_F   = 3'b011;
   localparam logic [2:0] MODE_C   = 3'b100;
   localparam logic [2:0] MODE_RST = 3'b101;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             mode_q, mode_d;
   logic [ID_Width-1:0]    pid_q, pid_d;
   logic [Bits-1:0]        data_q, data_d;
   logic [Bits-1:0]        mskb_q, mskb_d;
   logic [AddressSize-1:0] addr_q, addr_d;
   logic                   dcs_q, dcs_d;
   logic                   vbe_q, vbe_d;
   logic                   vbi_q, vbi_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [SW-1:0]          starve_q, starve_d;

   logic [ID_Width-1:0]    fifo_mem [FIFO_Depth];
   logic [ID_Width-1:0]    fifo_head;
   logic                   fifo_nonempty;
   logic                   force_spike;
   logic                   cfg_ready_c;
   logic                   cfg_grant;
   logic                   spike_grant;
   logic                   push;

   assign fifo_head = fifo_mem[rd_ptr_q];

   // Arbitration: config wins unless spikes have been starved for a full burst.
   always_comb begin
      fifo_nonempty = (count_q != '0);
      force_spike   = (starve_q == BURST_C) && fifo_nonempty;
      cfg_ready_c   = (state_q == ST_IDLE) && !force_spike;
      cfg_grant     = cfg_valid && cfg_ready_c;
      spike_grant   = (state_q == ST_IDLE) && fifo_nonempty && !cfg_grant;
      push          = spike_valid && (count_q != DEPTH_C);
   end

   // FIFO pointers, occupancy and the spike starvation counter.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      starve_d = starve_q;
      if (push)        wr_ptr_d = wr_ptr_q + PW'(1);
      if (spike_grant) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(spike_grant);
      if (!fifo_nonempty || spike_grant)
         starve_d = '0;
      else if (cfg_grant && (starve_q != BURST_C))
         starve_d = starve_q + SW'(1);
   end

   // Sequencer state and the next Mem pin pattern.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pid_d   = pid_q;
      data_d  = data_q;
      mskb_d  = mskb_q;
      addr_d  = addr_q;
      dcs_d   = dcs_q;
      vbe_d   = vbe_q;
      vbi_d   = vbi_q;
      case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
            mode_d  = MODE_I;
         end
         ST_ISSUE: begin
            // Idle pattern; Dcs and PacketID keep their last values.
            state_d = ST_IDLE;
            mode_d  = MODE_I;
            data_d  = '0;
            mskb_d  = '0;
            addr_d  = '0;
            vbe_d   = 1'b0;
            vbi_d   = 1'b0;
         end
         ST_IDLE: begin
            if (cfg_grant) begin
               state_d = ST_ISSUE;
               case (cfg_op)
                  2'b00: begin
                     mode_d = MODE_W;
                     data_d = cfg_data;
                     mskb_d = cfg_mskb;
                     addr_d = cfg_addr;
                     dcs_d  = cfg_dcs;
                     vbe_d  = cfg_vbe;
                     vbi_d  = cfg_vbi;
                  end
                  2'b01: begin
                     mode_d = MODE_R;
                     data_d = '0;
                     mskb_d = '0;
                     addr_d = cfg_addr;
                     dcs_d  = cfg_dcs;
                     vbe_d  = cfg_vbe;
                     vbi_d  = 1'b0;
                  end
                  2'b10: begin
                     mode_d = MODE_C;
                     data_d = cfg_data;
                     mskb_d = cfg_mskb;
                     addr_d = '0;
                     dcs_d  = cfg_dcs;
                     vbe_d  = 1'b0;
                     vbi_d  = 1'b0;
                  end
                  default: begin
                     // Soft reset of Mem only; queued spikes are kept.
                     mode_d = MODE_RST;
                     pid_d  = '0;
                     data_d = '0;
                     mskb_d = '0;
                     addr_d = '0;
                     dcs_d  = 1'b0;
                     vbe_d  = 1'b0;
                     vbi_d  = 1'b0;
                  end
               endcase
            end else if (spike_grant) begin
               state_d = ST_ISSUE;
               mode_d  = MODE_F;
               pid_d   = fifo_head;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // All state and registered Mem outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_INIT;
         mode_q   <= MODE_RST;
         pid_q    <= '0;
         data_q   <= '0;
         mskb_q   <= '0;
         addr_q   <= '0;
         dcs_q    <= 1'b0;
         vbe_q    <= 1'b0;
         vbi_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         pid_q    <= pid_d;
         data_q   <= data_d;
         mskb_q   <= mskb_d;
         addr_q   <= addr_d;
         dcs_q    <= dcs_d;
         vbe_q    <= vbe_d;
         vbi_q    <= vbi_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   // Spike storage; contents are ignored after reset because the pointers clear.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= spike_id;
   end

   assign spike_ready = (count_q != DEPTH_C);
   assign cfg_ready   = cfg_ready_c;
   assign MODE        = mode_q;
   assign PacketID_In = pid_q;
   assign Data_In     = data_q;
   assign Mskb_In     = mskb_q;
   assign A_In        = addr_q;
   assign Dcs_In      = dcs_q;
   assign Vbe_In      = vbe_q;
   assign Vbi_In      = vbi_q;
   assign fifo_count  = count_q;

endmodule
